// File: rtl/trace_line_parser_if.sv
// Byte-in / record-out bus of trace_line_parser.
// The slave modport is the parser's view. The master modport is the view of the reader and consumer.
interface trace_line_parser_if #(
  parameter int ADDR_W = 32
) ();
  logic              in_en;
  logic [7:0]        in_byte;
  logic              rec_valid;
  logic              rec_ready;
  logic              rec_op;
  logic [ADDR_W-1:0] rec_addr;
  logic              parse_err;
  logic              overflow;

  modport slave (
    input  in_en, in_byte, rec_ready,
    output rec_valid, rec_op, rec_addr, parse_err, overflow
  );

  modport master (
    output in_en, in_byte, rec_ready,
    input  rec_valid, rec_op, rec_addr, parse_err, overflow
  );
endinterface

// File: rtl/trace_line_parser.sv
// Parses ASCII "op addr" trace lines into {op, addr} records and buffers them in a small FIFO.
// Defining TRACE_PARSER_STATS_EN adds the rec_count and err_count statistics ports.
module trace_line_parser #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  trace_line_parser_if.slave bus
`ifdef TRACE_PARSER_STATS_EN
  ,
  output logic [31:0] rec_count,
  output logic [15:0] err_count
`endif
);
  localparam int MAXDIG = ADDR_W / 4;
  localparam int NDIG_W = $clog2(MAXDIG + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, SEP, ZERO, HEX, TAIL, COMMENT, ERR_SKIP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_op, w_op_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [NDIG_W-1:0] r_ndig, w_ndig_nxt;
  logic              r_sep_seen, w_sep_nxt;
  logic              w_err, w_emit;
  logic              r_parse_err, r_overflow;

  // Byte classification
  logic [7:0] w_b;
  logic       w_ws, w_lf, w_is_op, w_op_wr, w_is_x, w_is_hex;
  logic [3:0] w_nib;
  logic [ADDR_W-1:0] w_addr_shift;

  assign w_b     = bus.in_byte;
  assign w_ws    = (w_b == 8'h20) || (w_b == 8'h09) || (w_b == 8'h0D);
  assign w_lf    = (w_b == 8'h0A);
  assign w_op_wr = (w_b == 8'h57) || (w_b == 8'h77);
  assign w_is_op = w_op_wr || (w_b == 8'h52) || (w_b == 8'h72);
  assign w_is_x  = (w_b == 8'h78) || (w_b == 8'h58);
  assign w_addr_shift = (r_addr << 4) | ADDR_W'(w_nib);

  always_comb begin
    w_is_hex = 1'b1;
    w_nib    = 4'h0;
    if (w_b >= 8'h30 && w_b <= 8'h39)
      w_nib = w_b[3:0];
    else if ((w_b >= 8'h61 && w_b <= 8'h66) || (w_b >= 8'h41 && w_b <= 8'h46))
      w_nib = w_b[3:0] + 4'd9;
    else
      w_is_hex = 1'b0;
  end

  // Next-state logic. Error and emit both override the per-state target.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr;
    w_ndig_nxt  = r_ndig;
    w_sep_nxt   = r_sep_seen;
    w_err       = 1'b0;
    w_emit      = 1'b0;
    if (bus.in_en) begin
      case (r_state)
        IDLE: begin
          if (w_ws || w_lf) begin
          end else if (w_is_op) begin
            w_op_nxt    = w_op_wr;
            w_sep_nxt   = 1'b0;
            w_state_nxt = SEP;
          end else if (w_b == 8'h23) begin
            w_state_nxt = COMMENT;
          end else begin
            w_err = 1'b1;
          end
        end
        SEP: begin
          if (w_ws) begin
            w_sep_nxt = 1'b1;
          end else if (w_is_hex && r_sep_seen) begin
            w_addr_nxt  = ADDR_W'(w_nib);
            w_ndig_nxt  = NDIG_W'(1);
            w_state_nxt = (w_nib == 4'h0) ? ZERO : HEX;
          end else begin
            w_err = 1'b1;
          end
        end
        ZERO: begin
          if (w_is_x) begin
            w_ndig_nxt  = '0;
            w_state_nxt = HEX;
          end else if (w_is_hex && MAXDIG >= 2) begin
            w_addr_nxt  = w_addr_shift;
            w_ndig_nxt  = NDIG_W'(2);
            w_state_nxt = HEX;
          end else if (w_ws) begin
            w_state_nxt = TAIL;
          end else if (w_lf) begin
            w_emit = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        HEX: begin
          if (w_is_hex) begin
            if (r_ndig == NDIG_W'(MAXDIG)) begin
              w_err = 1'b1;
            end else begin
              w_addr_nxt = w_addr_shift;
              w_ndig_nxt = r_ndig + NDIG_W'(1);
            end
          end else if (w_ws && r_ndig != '0) begin
            w_state_nxt = TAIL;
          end else if (w_lf && r_ndig != '0) begin
            w_emit = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        TAIL: begin
          if (w_lf)       w_emit = 1'b1;
          else if (!w_ws) w_err  = 1'b1;
        end
        COMMENT, ERR_SKIP: begin
          if (w_lf) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_emit) w_state_nxt = IDLE;
      if (w_err)  w_state_nxt = w_lf ? IDLE : ERR_SKIP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= 1'b0;
      r_addr     <= '0;
      r_ndig     <= '0;
      r_sep_seen <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_addr     <= w_addr_nxt;
      r_ndig     <= w_ndig_nxt;
      r_sep_seen <= w_sep_nxt;
    end
  end

  // Record FIFO. Outputs are forced to zero when the FIFO is empty, so the memory needs no reset.
  logic [ADDR_W:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_valid, w_pop, w_full, w_push, w_drop;
  logic [ADDR_W:0]  w_head;

  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid && bus.rec_ready;
  assign w_full  = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign w_push  = w_emit && (!w_full || w_pop);
  assign w_drop  = w_emit && w_full && !w_pop;
  assign w_head  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {r_op, r_addr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_parse_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
      r_parse_err <= w_err;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.rec_valid = w_valid;
  assign bus.rec_op    = w_valid ? w_head[ADDR_W] : 1'b0;
  assign bus.rec_addr  = w_valid ? w_head[ADDR_W-1:0] : '0;
  assign bus.parse_err = r_parse_err;
  assign bus.overflow  = r_overflow;

`ifdef TRACE_PARSER_STATS_EN
  logic [31:0] r_rec_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rec_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_push) r_rec_count <= r_rec_count + 32'd1;
      if (w_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign rec_count = r_rec_count;
  assign err_count = r_err_count;
`endif
endmodule

// File: doc/trace_line_parser.md
# trace_line_parser

Consumes the byte stream produced by the SD-card file reader (one byte per `in_en` pulse, no backpressure) and parses the ASCII memory-access trace (`art.trace`) into binary records of an operation bit and an address. Records are buffered in a small FIFO and presented with a valid/ready handshake to the downstream LRU cache model. Malformed lines are discarded and counted; the parser resynchronises at the next line feed.

## Interface
- `ADDR_W`, 32, address width in bits; must be a multiple of 4 and at most 64.
- `FIFO_DEPTH`, 4, record FIFO depth; must be a power of 2 and at least 2.
- `clk` input 1: single clock, shared with the file reader.
- `rst` input 1: synchronous, active-high reset.
- `in_en` input 1: byte strobe, one cycle per byte.
- `in_byte` input 8: ASCII byte; sampled only when `in_en`=1.
- `rec_valid` output 1: FIFO head holds a record.
- `rec_ready` input 1: consumer accepts the head record when it is high together with `rec_valid`.
- `rec_op` output 1: operation of the head record; 0 = read, 1 = write.
- `rec_addr` output ADDR_W: address of the head record.
- `parse_err` output 1: one-cycle pulse when a line is rejected.
- `overflow` output 1: sticky flag, set when a completed record is dropped because the FIFO is full.
- `rec_count` output 32 (only with the macro): number of records pushed into the FIFO.
- `err_count` output 16 (only with the macro): number of rejected lines; saturates at 0xFFFF.

## Operation
- Line grammar, in order:
  - optional leading whitespace;
  - an op character: `R`/`r` for read, `W`/`w` for write;
  - one or more whitespace characters;
  - an optional `0x`/`0X` prefix;
  - 1 to ADDR_W/4 hex digits (`0-9`, `a-f`, `A-F`);
  - optional trailing whitespace;
  - LF.
- Whitespace means space, TAB or CR.
- Bytes are processed only on cycles with `in_en`=1. With `in_en`=0 the state does not change.
- States and transitions:
  - `IDLE`:
    - whitespace or LF: stay;
    - op character: latch op, go to `SEP`;
    - `#`: go to `COMMENT`;
    - anything else: error.
  - `SEP`:
    - whitespace: stay, but only after at least one whitespace byte has been seen;
    - `0`: set addr=0, ndig=1, go to `ZERO`;
    - any other hex digit: set addr=digit, ndig=1, go to `HEX`;
    - LF, non-hex byte, or a digit arriving before any whitespace: error.
  - `ZERO`:
    - `x`/`X`: set ndig=0, go to `HEX`;
    - hex digit: shift it in, ndig=2, go to `HEX`;
    - whitespace: go to `TAIL`;
    - LF: emit address 0;
    - anything else: error.
  - `HEX`:
    - hex digit: `addr <= {addr[ADDR_W-5:0], nibble}` and ndig++; if ndig already equals ADDR_W/4, error instead;
    - whitespace: go to `TAIL` if ndig>0, otherwise error;
    - LF: emit if ndig>0, otherwise error;
    - anything else: error.
  - `TAIL`:
    - whitespace: stay;
    - LF: emit;
    - anything else: error.
  - `COMMENT`: LF returns to `IDLE`, silently, with no error.
  - `ERR_SKIP`: LF returns to `IDLE`; all other bytes are ignored.
- Error actions:
  - pulse `parse_err`;
  - increment `err_count`;
  - if the offending byte is LF, go directly to `IDLE`; otherwise go to `ERR_SKIP`.
- Emit: push {op, addr} into the FIFO and go to `IDLE`. If the FIFO is full and no pop happens in the same cycle, drop the record and set `overflow`.
- FIFO behaviour:
  - pop on `rec_valid && rec_ready`;
  - push and pop in the same cycle are both honoured, including when the FIFO is full;
  - `rec_op`/`rec_addr` are stable while `rec_valid`=1 and `rec_ready`=0.
- A final line with no terminating LF is never emitted.

## Timing
- The FSM advances one byte per `in_en` cycle, and back-to-back `in_en` is supported.
- Latency: a record pushed on the LF cycle raises `rec_valid` on the next cycle, provided the FIFO was empty.
- `parse_err` is asserted in the cycle after the offending byte is sampled, for exactly one cycle.
- Reset values:
  - FSM in `IDLE`, FIFO empty;
  - `rec_valid`=0, `rec_op`=0, `rec_addr`=0;
  - `parse_err`=0, `overflow`=0;
  - counters = 0.
- Reset asserted mid-line discards the partial line and flushes the FIFO.
- Reset takes priority over `in_en` and `rec_ready` in the same cycle.

## Configuration
- `TRACE_PARSER_STATS_EN` defined: the `rec_count` and `err_count` ports and their counters exist.
  - `rec_count` increments on every successful push; overflow drops are not counted.
  - `err_count` increments on every `parse_err`.
- `TRACE_PARSER_STATS_EN` undefined: both ports and counters are absent.
  - `parse_err` and `overflow` behave identically in both builds.

## Test plan
- Bytes "R 1a2B\n", `rec_ready`=1: one record, `rec_op`=0, `rec_addr`=0x00001A2B; `rec_valid` high exactly one cycle, starting the cycle after LF.
- Bytes "w 0xDEADBEEF\r\n" then "  r\t0\n", with `in_en` gapped randomly: records (1, 0xDEADBEEF) then (0, 0x00000000); no `parse_err`.
- Bytes "Q 12\nR 123456789\nR\n# note\nW 5\n": `parse_err` pulses 3 times; only (1, 0x5) is emitted; `err_count`=3 and `rec_count`=1 with the macro.
- `rec_ready`=0 and 5 lines "R 1\n".."R 5\n" with `FIFO_DEPTH`=4: addresses 1–4 are buffered, `overflow`=1, and draining yields 1, 2, 3, 4 in order.
- FIFO full, then the LF of "W 9\n" arrives in the same cycle as a pop: both are honoured, `overflow` stays 0, and 9 is the last record drained.
- `rst` pulsed after "W 12" with no LF, then "R 7\n": only (0, 0x7) is emitted; all outputs read 0 in the cycle after the reset edge.
